// File: rtl/piksel_filtre_yanitlayici_pkg.sv
// Shared types and constants for the pixel filter responder.
package gorev_paket;

  localparam int unsigned PIKSEL_W             = 8;
  localparam int unsigned VARSAYILAN_GENISLIK  = 320;
  localparam int unsigned VARSAYILAN_YUKSEKLIK = 240;

  typedef logic [2:0] durum_t;

  localparam durum_t BOSTA  = 3'd0;
  localparam durum_t AL     = 3'd1;
  localparam durum_t GONDER = 3'd2;
  localparam durum_t KENAR  = 3'd3;
  localparam durum_t BITTI  = 3'd4;

endpackage

// File: rtl/piksel_filtre_yanitlayici_if.sv
// Pixel-stream handshake between the image top level (master) and the filter (slave).
interface piksel_filtre_yanitlayici_if;
  import gorev_paket::*;

  logic [PIKSEL_W-1:0] veri_i;
  logic                veri_gecerli_i;
  logic                veri_al_o;
  logic [PIKSEL_W-1:0] veri_o;
  logic                veri_gonder_o;
  logic                veri_alindi_i;
  logic                islem_bitti_o;

  modport slave (
    input  veri_i, veri_gecerli_i, veri_alindi_i,
    output veri_al_o, veri_o, veri_gonder_o, islem_bitti_o
  );

  modport master (
    output veri_i, veri_gecerli_i, veri_alindi_i,
    input  veri_al_o, veri_o, veri_gonder_o, islem_bitti_o
  );

endinterface

// File: rtl/piksel_filtre_yanitlayici_satir_cekirdegi.sv
// Combinational 1-2-1 horizontal kernel; optional threshold when GOREV_ESIK_EN is defined.
module satir_cekirdegi
  import gorev_paket::*;
#(
  parameter int unsigned ESIK = 128
) (
  input  logic [PIKSEL_W-1:0] a_i,
  input  logic [PIKSEL_W-1:0] b_i,
  input  logic [PIKSEL_W-1:0] c_i,
  output logic [PIKSEL_W-1:0] sonuc_o
);

`ifdef GOREV_ESIK_EN
  localparam bit EsikAktif = 1'b1;
`else
  localparam bit EsikAktif = 1'b0;
`endif

  logic [PIKSEL_W+1:0] toplam;
  logic [PIKSEL_W-1:0] ham;

  // Max sum is 4*255 = 1020, so the 10-bit sum never overflows.
  assign toplam  = {2'b00, a_i} + {1'b0, b_i, 1'b0} + {2'b00, c_i};
  assign ham     = toplam[PIKSEL_W+1:2];
  assign sonuc_o = !EsikAktif ? ham : ((ham >= PIKSEL_W'(ESIK)) ? '1 : '0);

endmodule

// File: rtl/piksel_filtre_yanitlayici.sv
// Raster-order 1-2-1 smoothing responder with edge replication.
// Optional threshold output enabled by the GOREV_ESIK_EN macro.
module piksel_filtre_yanitlayici
  import gorev_paket::*;
#(
  parameter int unsigned GENISLIK  = VARSAYILAN_GENISLIK,
  parameter int unsigned YUKSEKLIK = VARSAYILAN_YUKSEKLIK,
  parameter int unsigned ESIK      = 128
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  piksel_filtre_yanitlayici_if.slave   pf_io
);

  localparam int unsigned TOPLAM  = GENISLIK * YUKSEKLIK;
  localparam int unsigned SUTUN_W = $clog2(GENISLIK);
  localparam int unsigned SAYAC_W = $clog2(TOPLAM + 1);

  durum_t              durum_q, durum_d;
  logic [SUTUN_W-1:0]  sutun_q, sutun_d;
  logic [SAYAC_W-1:0]  sayac_q, sayac_d, sayac_art;
  logic [PIKSEL_W-1:0] onceki_q, onceki_d;
  logic [PIKSEL_W-1:0] simdi_q, simdi_d;
  logic [PIKSEL_W-1:0] veri_q, veri_d;
  logic                kenar_q, kenar_d;
  logic [PIKSEL_W-1:0] cek_c, cek_sonuc;

  // In GONDER the registers already hold the shifted pair, so the right edge
  // is replicated by feeding cur twice.
  assign cek_c = (durum_q == AL) ? pf_io.veri_i : simdi_q;

  satir_cekirdegi #(
    .ESIK (ESIK)
  ) u_cekirdek (
    .a_i     (onceki_q),
    .b_i     (simdi_q),
    .c_i     (cek_c),
    .sonuc_o (cek_sonuc)
  );

  assign sayac_art = sayac_q + 1'b1;

  always_comb begin
    durum_d  = durum_q;
    sutun_d  = sutun_q;
    sayac_d  = sayac_q;
    onceki_d = onceki_q;
    simdi_d  = simdi_q;
    veri_d   = veri_q;
    kenar_d  = kenar_q;
    if (!en_i) begin
      durum_d = BOSTA;
      sutun_d = '0;
      sayac_d = '0;
      kenar_d = 1'b0;
      veri_d  = '0;
    end else begin
      case (durum_q)
        BOSTA: begin
          durum_d = AL;
          sutun_d = '0;
          sayac_d = '0;
          kenar_d = 1'b0;
        end
        AL: begin
          if (pf_io.veri_gecerli_i) begin
            simdi_d  = pf_io.veri_i;
            onceki_d = simdi_q;
            if (sutun_q == '0) begin
              onceki_d = pf_io.veri_i;
              sutun_d  = SUTUN_W'(1);
            end else begin
              veri_d  = cek_sonuc;
              durum_d = GONDER;
              if (sutun_q == SUTUN_W'(GENISLIK - 1)) begin
                sutun_d = '0;
                kenar_d = 1'b1;
              end else begin
                sutun_d = sutun_q + 1'b1;
              end
            end
          end
        end
        GONDER: begin
          if (pf_io.veri_alindi_i) begin
            sayac_d = sayac_art;
            if (kenar_q) begin
              kenar_d = 1'b0;
              veri_d  = cek_sonuc;
              durum_d = KENAR;
            end else if (sayac_art == SAYAC_W'(TOPLAM)) begin
              durum_d = BITTI;
            end else begin
              durum_d = AL;
            end
          end
        end
        KENAR: begin
          if (pf_io.veri_alindi_i) begin
            sayac_d = sayac_art;
            durum_d = (sayac_art == SAYAC_W'(TOPLAM)) ? BITTI : AL;
          end
        end
        BITTI:   durum_d = BITTI;
        default: durum_d = BOSTA;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q  <= BOSTA;
      sutun_q  <= '0;
      sayac_q  <= '0;
      onceki_q <= '0;
      simdi_q  <= '0;
      veri_q   <= '0;
      kenar_q  <= 1'b0;
    end else begin
      durum_q  <= durum_d;
      sutun_q  <= sutun_d;
      sayac_q  <= sayac_d;
      onceki_q <= onceki_d;
      simdi_q  <= simdi_d;
      veri_q   <= veri_d;
      kenar_q  <= kenar_d;
    end
  end

  assign pf_io.veri_al_o     = (durum_q == AL);
  assign pf_io.veri_gonder_o = (durum_q == GONDER) || (durum_q == KENAR);
  assign pf_io.islem_bitti_o = (durum_q == BITTI);
  assign pf_io.veri_o        = veri_q;

endmodule

// File: doc/piksel_filtre_yanitlayici.md
# piksel_filtre_yanitlayici

Image-processing responder on the sub-module side of the pixel-stream handshake used by the image top level. It requests 8-bit grayscale pixels in raster order and applies a horizontal 1-2-1 smoothing kernel with edge replication. It returns one filtered pixel per input pixel and raises a completion flag after the last pixel of the frame is delivered. The top level feeds it from RAM1 and collects its output into RAM2.

## Interface
- GENISLIK, 320, pixels per row (≥2)
- YUKSEKLIK, 240, rows per frame (≥1)
- ESIK, 128, threshold level (used only with GOREV_ESIK_EN)
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  reset; one clock; reset is asynchronous and active-high
- en_i  input  1  frame enable; low aborts and returns to BOSTA
- veri_i  input  8  input pixel
- veri_gecerli_i  input  1  veri_i valid
- veri_al_o  output  1  ready to accept a pixel; reset 0
- veri_o  output  8  filtered pixel; reset 0
- veri_gonder_o  output  1  veri_o valid; reset 0
- veri_alindi_i  input  1  host accepts veri_o
- islem_bitti_o  output  1  frame complete; reset 0

## Operation
- Input transfer: veri_al_o & veri_gecerli_i at a rising edge. Output transfer: veri_gonder_o & veri_alindi_i at a rising edge.
- States:
  - BOSTA: wait for en_i.
  - AL: veri_al_o=1.
  - GONDER: veri_gonder_o=1.
  - KENAR: second output of a row end.
  - BITTI: islem_bitti_o=1.
- BOSTA→AL when en_i=1. Column and row counters are cleared.
- In AL, a pixel accepted at column c advances as follows:
  - c=0: store it as cur and prev, with no output; stay in AL.
  - 0<c<GENISLIK-1: output for column c-1 = (prev + 2·cur + new) >> 2; go to GONDER. Then prev←cur, cur←new.
  - c=GENISLIK-1: emit column c-1 as above, then go to GONDER with a pending flag set. After that transfer, go to KENAR and emit column c = (cur + 3·new) >> 2. Here cur is the shifted value, i.e. the replicated edge is new.
- Column 0 output = (3·p0 + p1) >> 2.
- Arithmetic: 10-bit sum, truncating shift. The result always fits 8 bits; there is no saturation.
- Output counter counts transfers. After transfer number GENISLIK·YUKSEKLIK, go to BITTI.
- BITTI holds until en_i=0, then goes to BOSTA and clears islem_bitti_o.
- Only one output is ever pending. veri_al_o is 0 whenever veri_gonder_o is 1.
- veri_gecerli_i is ignored outside AL. veri_alindi_i is ignored while veri_gonder_o=0.
- en_i=0 in any state: on the next edge go to BOSTA, clear all counters and drop the pending output. All outputs go to their reset values.
- Asynchronous rst_i mid-frame: immediate return to reset values. The next frame starts from column 0.

## Timing
- Input accepted at edge N → veri_gonder_o=1 with veri_o valid after edge N (registered), visible in cycle N+1.
- veri_o and veri_gonder_o stay stable until the transfer edge.
- After a GONDER transfer at edge M:
  - veri_al_o=1 after edge M, or
  - KENAR valid after edge M at row end.
- Peak throughput is 1 pixel per 2 cycles. A row takes GENISLIK input transfers and GENISLIK output transfers.
- islem_bitti_o rises after the edge of the final output transfer.

## Configuration
- GOREV_ESIK_EN defined: the filtered value passes through a threshold. The output is 255 if the result ≥ ESIK, otherwise 0.
- GOREV_ESIK_EN undefined: the raw filtered value is output and ESIK is unused.
- Timing is identical in both builds.

## Structure
- Package gorev_paket holds:
  - the state typedef (BOSTA, AL, GONDER, KENAR, BITTI);
  - the pixel width constant (8);
  - the default GENISLIK and YUKSEKLIK.
- Sub-module satir_cekirdegi holds the 1-2-1 arithmetic and the optional threshold. It is combinational, taking inputs a, b, c and producing an 8-bit result.
- Counter widths are $clog2(GENISLIK) and $clog2(GENISLIK·YUKSEKLIK+1).

## Test plan
- Ramp row: GENISLIK=4, YUKSEKLIK=1, inputs 0,4,8,12, host always accepts → outputs 1,4,8,11; then islem_bitti_o=1.
- Flat frame: GENISLIK=320, YUKSEKLIK=240, every input 100 → 76800 outputs, all 100; islem_bitti_o rises exactly after the 76800th transfer.
- Impulse: GENISLIK=5, inputs 0,0,255,0,0 → outputs 0,63,127,63,0.
- Backpressure: veri_alindi_i held low for 5 cycles → veri_o stable, veri_gonder_o=1 and veri_al_o=0 throughout; no pixel is lost.
- Abort: rst_i pulsed at pixel 150 of a flat-200 frame → all outputs 0 immediately. A restarted frame gives a correct first output of 200. Repeat with en_i=0 mid-frame → BOSTA next cycle.
- GOREV_ESIK_EN with ESIK=128: constant 200 → all outputs 255; constant 100 → all outputs 0.
